// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pipe_ctrl_pkg;

    // Address/data word helpers shared across the core
    localparam int AddrBus_W = 32;
    typedef logic [AddrBus_W-1:0] addr_t;
    localparam addr_t ZeroWord = 32'h0000_0000;

    // Stall vector layout: bit k freezes pipeline register feeding stage k
    localparam int STALL_W   = 5;
    localparam int STALL_IF  = 0;
    localparam int STALL_ID  = 1;
    localparam int STALL_EX  = 2;
    localparam int STALL_MEM = 3;
    localparam int STALL_WB  = 4;

    // A stall at stage k also freezes every stage upstream of k
    localparam logic [STALL_W-1:0] STALL_NONE     = 5'b00000;
    localparam logic [STALL_W-1:0] STALL_THRU_IF  = 5'b00001;
    localparam logic [STALL_W-1:0] STALL_THRU_ID  = 5'b00011;
    localparam logic [STALL_W-1:0] STALL_THRU_EX  = 5'b00111;
    localparam logic [STALL_W-1:0] STALL_THRU_MEM = 5'b01111;
    localparam logic [STALL_W-1:0] STALL_ALL      = 5'b11111;

    // Default exception handler address (bootstrap exception vector)
    localparam addr_t EXC_VECTOR_DEF = 32'hBFC0_0380;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } pc_state_t;

endpackage

// File: rtl/pipe_ctrl_prio.sv
// Stall-request priority encoder: deepest requesting stage wins.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; output is the stall mask only.
module pipe_ctrl_prio
    import pipe_ctrl_pkg::*;
(
    input  logic               i_if_req,
    input  logic               i_id_req,
    input  logic               i_ex_req,
    input  logic               i_mem_req,
    output logic [STALL_W-1:0] o_stall
);

    // Deepest stage takes precedence since it freezes everything behind it;
    // the wb bit is never set here, only the drain path freezes writeback.
    always_comb begin
        o_stall = STALL_NONE;
        if (i_mem_req) begin
            o_stall = STALL_THRU_MEM;
        end else if (i_ex_req) begin
            o_stall = STALL_THRU_EX;
        end else if (i_id_req) begin
            o_stall = STALL_THRU_ID;
        end else if (i_if_req) begin
            o_stall = STALL_THRU_IF;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall merge, exception flush/redirect, dbus drain with watchdog abort.
// Latency: stall 0 cycles; flush 0 cycles if dbus idle, else busy cycles + 1 (<= DRAIN_TIMEOUT+1).
// Backpressure: freezes all five stages while draining; flush overrides every stall request.
// Optional: define PIPE_CTRL_PERF_EN to add saturating perf_stall_cnt / perf_flush_cnt outputs.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter addr_t EXC_VECTOR    = EXC_VECTOR_DEF,
    parameter int    DRAIN_TIMEOUT = 64,
    parameter int    CNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_stallreq,
    input  logic               id_stallreq,
    input  logic               ex_stallreq,
    input  logic               mem_stallreq,
    input  logic               mem_excp,
    input  logic               mem_eret,
    input  logic [31:0]        cp0_epc,
    input  logic               dbus_busy,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic [31:0]        new_pc,
    output logic               dbus_abort
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_flush_cnt
`endif
);

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] WD_ONE  = CNT_W'(1);

    pc_state_t          r_state;
    logic [CNT_W-1:0]   r_wdog;
    addr_t              r_target;

    logic [STALL_W-1:0] w_req_stall;
    addr_t              w_sel_target;
    logic               w_timeout;

    pipe_ctrl_prio u_prio (
        .i_if_req  (if_stallreq),
        .i_id_req  (id_stallreq),
        .i_ex_req  (ex_stallreq),
        .i_mem_req (mem_stallreq),
        .o_stall   (w_req_stall)
    );

    // ERET returns to EPC; every other exception goes to the handler vector
    assign w_sel_target = mem_eret ? cp0_epc : EXC_VECTOR;

    // Watchdog expires on its last DRAIN cycle only if the bus is still busy
    assign w_timeout = (r_state == ST_DRAIN) && dbus_busy && (r_wdog == WD_LAST);

    // Mealy outputs: exception in RUN with idle bus flushes in the same cycle
    always_comb begin
        stall      = STALL_NONE;
        flush      = 1'b0;
        new_pc     = ZeroWord;
        dbus_abort = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_RUN: begin
                    if (mem_excp) begin
                        if (dbus_busy) begin
                            stall = STALL_ALL;
                        end else begin
                            flush  = 1'b1;
                            new_pc = w_sel_target;
                        end
                    end else begin
                        stall = w_req_stall;
                    end
                end
                ST_DRAIN: begin
                    stall      = STALL_ALL;
                    dbus_abort = w_timeout;
                end
                ST_FLUSH: begin
                    flush  = 1'b1;
                    new_pc = r_target;
                end
                default: begin
                    stall = STALL_NONE;
                end
            endcase
        end
    end

    // Sequencer state, drain watchdog and latched redirect target
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_wdog   <= '0;
            r_target <= ZeroWord;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (mem_excp && dbus_busy) begin
                        r_target <= w_sel_target;
                        r_wdog   <= '0;
                        r_state  <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_wdog <= r_wdog + WD_ONE;
                    if (!dbus_busy || w_timeout) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    // Saturating counts of cycles with any stall and cycles with flush
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if ((stall != STALL_NONE) && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (flush && (r_perf_flush != 32'hFFFF_FFFF)) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = r_perf_stall;
    assign perf_flush_cnt = r_perf_flush;
`endif

endmodule
